// File: rtl/arp_sequencer.sv
// Step sequencer feeding the square-wave tone generator: plays an
// 8-entry pitch table in order, one entry per fixed-length step.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   WR_EN, WR_ADDR, WR_DATA       pitch table write port (0 = rest)
//   START, STOP                   one-cycle playback control pulses
//   LEN                           last step index, latched on START
//   LOOP                          wrap to step 0 after the last step
//   PERIOD, GATE                  tone generator drive
//   STEP_IDX, STEP_STROBE         current step and first-cycle pulse
//   BUSY, DONE                    playing / end-of-run pulse
module arp_sequencer #(
    parameter int PW          = 24,
    parameter int STEP_CYCLES = 10000000,
    parameter int GAP_CYCLES  = 1000000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WR_EN,
    input  logic [2:0]    WR_ADDR,
    input  logic [PW-1:0] WR_DATA,
    input  logic          START,
    input  logic          STOP,
    input  logic [2:0]    LEN,
    input  logic          LOOP,
    output logic [PW-1:0] PERIOD,
    output logic          GATE,
    output logic [2:0]    STEP_IDX,
    output logic          STEP_STROBE,
    output logic          BUSY,
    output logic          DONE
);

    localparam int TW = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0] LAST_TICK = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST = TW'(STEP_CYCLES - GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t          state_q, state_n;
    logic [TW-1:0]   tick_q, tick_n;
    logic [2:0]      len_q, len_n;
    logic [PW-1:0]   pitch_q [8];

    logic [PW-1:0]   period_n;
    logic            gate_n;
    logic [2:0]      idx_n;
    logic            strobe_n;
    logic            busy_n;
    logic            done_n;

    logic            load;
    logic [2:0]      load_idx;
    logic            step_end;

    // Pitch table; a load in the same cycle as a write sees the old entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                pitch_q[i] <= '0;
            end
        end else if (WR_EN) begin
            pitch_q[WR_ADDR] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            len_q       <= '0;
            PERIOD      <= '0;
            GATE        <= 1'b0;
            STEP_IDX    <= '0;
            STEP_STROBE <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            state_q     <= state_n;
            tick_q      <= tick_n;
            len_q       <= len_n;
            PERIOD      <= period_n;
            GATE        <= gate_n;
            STEP_IDX    <= idx_n;
            STEP_STROBE <= strobe_n;
            BUSY        <= busy_n;
            DONE        <= done_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q;
        len_n    = len_q;
        period_n = PERIOD;
        gate_n   = GATE;
        idx_n    = STEP_IDX;
        strobe_n = 1'b0;
        busy_n   = BUSY;
        done_n   = 1'b0;
        load     = 1'b0;
        load_idx = '0;

        // With no gap the step ends from PLAY; otherwise from GAP.
        step_end = (tick_q == LAST_TICK) &&
                   ((state_q == GAP) ||
                    (state_q == PLAY && GAP_CYCLES == 0));

        if (STOP) begin
            state_n = IDLE;
            gate_n  = 1'b0;
            busy_n  = 1'b0;
        end else if (START) begin
            len_n    = LEN;
            load     = 1'b1;
            load_idx = '0;
        end else begin
            unique case (state_q)
                PLAY: begin
                    tick_n = tick_q + TW'(1);
                    if (GAP_CYCLES > 0 && tick_q == GATE_LAST) begin
                        state_n = GAP;
                        gate_n  = 1'b0;
                    end
                end
                GAP: begin
                    tick_n = tick_q + TW'(1);
                end
                default: begin
                end
            endcase

            if (step_end) begin
                if (STEP_IDX != len_q) begin
                    load     = 1'b1;
                    load_idx = STEP_IDX + 3'd1;
                end else if (LOOP) begin
                    load     = 1'b1;
                    load_idx = '0;
                end else begin
                    state_n = IDLE;
                    gate_n  = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
        end

        if (load) begin
            period_n = pitch_q[load_idx];
            gate_n   = (pitch_q[load_idx] != '0);
            idx_n    = load_idx;
            strobe_n = 1'b1;
            busy_n   = 1'b1;
            tick_n   = '0;
            state_n  = PLAY;
        end
    end

endmodule

// File: tb/tb_arp_sequencer.sv
// Directed bench for arp_sequencer with 8-cycle steps and a 2-cycle gap.
// Expected outputs come from a hand-kept copy of the pitch table.
module tb_arp_sequencer;

    localparam int PW = 24;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          WR_EN = 1'b0;
    logic [2:0]    WR_ADDR = '0;
    logic [PW-1:0] WR_DATA = '0;
    logic          START = 1'b0;
    logic          STOP = 1'b0;
    logic [2:0]    LEN = '0;
    logic          LOOP = 1'b0;
    logic [PW-1:0] PERIOD;
    logic          GATE;
    logic [2:0]    STEP_IDX;
    logic          STEP_STROBE;
    logic          BUSY;
    logic          DONE;

    int n_chk = 0;
    int n_fail = 0;

    logic [PW-1:0] tbl [4];

    arp_sequencer #(
        .PW(PW),
        .STEP_CYCLES(8),
        .GAP_CYCLES(2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA),
        .START(START),
        .STOP(STOP),
        .LEN(LEN),
        .LOOP(LOOP),
        .PERIOD(PERIOD),
        .GATE(GATE),
        .STEP_IDX(STEP_IDX),
        .STEP_STROBE(STEP_STROBE),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cyc(input int idx, input logic [PW-1:0] p,
                             input int t);
        chk("strobe", 32'(STEP_STROBE), 32'(t == 0));
        chk("period", 32'(PERIOD), 32'(p));
        chk("gate", 32'(GATE), 32'((p != 0) && (t < 6)));
        chk("idx", 32'(STEP_IDX), 32'(idx));
        chk("busy", 32'(BUSY), 32'd1);
        chk("done", 32'(DONE), 32'd0);
    endtask

    task automatic check_step(input int idx, input logic [PW-1:0] p);
        for (int t = 0; t < 8; t++) begin
            check_cyc(idx, p, t);
            tick();
        end
    endtask

    task automatic check_done(input int idx, input logic [PW-1:0] p);
        chk("done_pulse", 32'(DONE), 32'd1);
        chk("done_busy", 32'(BUSY), 32'd0);
        chk("done_gate", 32'(GATE), 32'd0);
        chk("done_strobe", 32'(STEP_STROBE), 32'd0);
        chk("done_idx", 32'(STEP_IDX), 32'(idx));
        chk("done_period", 32'(PERIOD), 32'(p));
        tick();
        chk("done_once", 32'(DONE), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_period"}, 32'(PERIOD), 32'd0);
        chk({tag, "_gate"}, 32'(GATE), 32'd0);
        chk({tag, "_idx"}, 32'(STEP_IDX), 32'd0);
        chk({tag, "_strobe"}, 32'(STEP_STROBE), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        tbl[0] = 24'd191116;
        tbl[1] = 24'd340529;
        tbl[2] = 24'd286352;
        tbl[3] = 24'd227272;

        tick();
        tick();
        RST = 1'b0;
        check_zero("reset");

        for (int i = 0; i < 4; i++) begin
            WR_EN = 1'b1;
            WR_ADDR = 3'(i);
            WR_DATA = tbl[i];
            tick();
        end
        WR_EN = 1'b0;

        // Four-step one-shot run
        LEN = 3'd3;
        LOOP = 1'b0;
        pulse_start();
        for (int s = 0; s < 4; s++) begin
            check_step(s, tbl[s]);
        end
        check_done(3, tbl[3]);

        // Looping two-step run, stopped mid step 1
        LEN = 3'd1;
        LOOP = 1'b1;
        pulse_start();
        check_step(0, tbl[0]);
        check_step(1, tbl[1]);
        check_step(0, tbl[0]);
        for (int t = 0; t < 4; t++) begin
            check_cyc(1, tbl[1], t);
            if (t < 3) tick();
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("stop_gate", 32'(GATE), 32'd0);
        chk("stop_busy", 32'(BUSY), 32'd0);
        chk("stop_idx", 32'(STEP_IDX), 32'd1);
        chk("stop_period", 32'(PERIOD), 32'(tbl[1]));
        chk("stop_done", 32'(DONE), 32'd0);
        tick();
        chk("stop_idle", 32'(BUSY), 32'd0);

        // Rest entry in the middle
        WR_EN = 1'b1;
        WR_ADDR = 3'd1;
        WR_DATA = '0;
        tick();
        WR_EN = 1'b0;
        LEN = 3'd2;
        LOOP = 1'b0;
        pulse_start();
        check_step(0, tbl[0]);
        check_step(1, '0);
        check_step(2, tbl[2]);
        check_done(2, tbl[2]);

        // Write collides with load of the same entry: old value plays
        LEN = 3'd1;
        LOOP = 1'b1;
        pulse_start();
        for (int t = 0; t < 8; t++) begin
            check_cyc(0, tbl[0], t);
            if (t == 7) begin
                WR_EN = 1'b1;
                WR_ADDR = 3'd1;
                WR_DATA = 24'd111111;
            end
            tick();
            WR_EN = 1'b0;
        end
        check_step(1, '0);
        // LEN change while busy is ignored; latched LEN=1 ends the run
        LOOP = 1'b0;
        LEN = 3'd3;
        check_step(0, tbl[0]);
        check_step(1, 24'd111111);
        check_done(1, 24'd111111);
        tbl[1] = 24'd111111;

        // Restart mid step 2 with LEN=0
        LEN = 3'd3;
        pulse_start();
        check_step(0, tbl[0]);
        check_step(1, tbl[1]);
        for (int t = 0; t < 4; t++) begin
            check_cyc(2, tbl[2], t);
            if (t < 3) tick();
        end
        LEN = 3'd0;
        pulse_start();
        check_step(0, tbl[0]);
        check_done(0, tbl[0]);

        // START and STOP together: stays idle
        START = 1'b1;
        STOP = 1'b1;
        tick();
        START = 1'b0;
        STOP = 1'b0;
        chk("ss_busy", 32'(BUSY), 32'd0);
        chk("ss_strobe", 32'(STEP_STROBE), 32'd0);
        chk("ss_gate", 32'(GATE), 32'd0);
        tick();
        chk("ss_idle", 32'(BUSY), 32'd0);

        // Reset during the gap clears outputs and table
        LEN = 3'd0;
        pulse_start();
        for (int t = 0; t < 7; t++) begin
            check_cyc(0, tbl[0], t);
            if (t < 6) tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_zero("midrst");
        pulse_start();
        check_step(0, '0);
        check_done(0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/arp_sequencer.md
Name: arp_sequencer

Overview:
- Step sequencer that drives the team's square-wave tone generator.
- Holds an 8-entry table of half-period-free "pitch" counts (generator wrap values, e.g. 382233 for C3 at 50 MHz) and plays them in order at a fixed step rate.
- Outputs the current PERIOD and a GATE to the tone generator. GATE low means speaker silent.
- Sits between the front-panel/host control logic and the tone generator; replaces the hard-coded pitch mux.

Parameters:
- PW, 24, width of a pitch entry and of PERIOD.
- STEP_CYCLES, 10000000, CLK cycles per step (≥2).
- GAP_CYCLES, 1000000, trailing cycles of each step with GATE forced low; must satisfy 0 ≤ GAP_CYCLES < STEP_CYCLES.

Ports:
- CLK  in  1  50 MHz system clock.
- RST  in  1  reset, synchronous, active-high.
- WR_EN  in  1  table write strobe.
- WR_ADDR  in  3  table entry to write.
- WR_DATA  in  PW  pitch count; 0 = rest.
- START  in  1  one-cycle pulse: begin/restart playback at step 0.
- STOP  in  1  one-cycle pulse: abort playback.
- LEN  in  3  last step index (steps played = LEN+1); latched on START.
- LOOP  in  1  1 = wrap to step 0 after last step; sampled at end of last step.
- PERIOD  out  PW  pitch count to tone generator.
- GATE  out  1  tone enable.
- STEP_IDX  out  3  index of step being played.
- STEP_STROBE  out  1  one-cycle pulse on first cycle of each step.
- BUSY  out  1  high while playing.
- DONE  out  1  one-cycle pulse when a non-looping run ends.

Behaviour:
- All outputs are registered. RST (synchronous, active-high) has priority over everything else. On RST:
  - state=IDLE.
  - tick counter=0, latched LEN=0.
  - all table entries=0.
  - PERIOD=0, GATE=0, STEP_IDX=0, STEP_STROBE=0, BUSY=0, DONE=0.
- States are IDLE, PLAY and GAP. tick counts 0..STEP_CYCLES-1 within a step and is sized to hold STEP_CYCLES-1.
- Step load (cycle after START, or cycle after a step ends with more to play):
  - PERIOD=table[idx], GATE=(table[idx]!=0), STEP_IDX=idx.
  - STEP_STROBE=1, BUSY=1, tick=0, state=PLAY.
  - START-to-first-strobe latency is 1 cycle.
- PLAY: tick increments each cycle.
  - At tick==STEP_CYCLES-GAP_CYCLES-1: if GAP_CYCLES>0, go to GAP, with GATE=0 from the next cycle.
  - If GAP_CYCLES==0, PLAY ends the step directly at tick==STEP_CYCLES-1.
- GAP: GATE=0 and PERIOD held. At tick==STEP_CYCLES-1 the step ends.
- Step end:
  - If STEP_IDX != latched LEN: load step STEP_IDX+1.
  - Else if LOOP=1: load step 0.
  - Else: state=IDLE, BUSY=0, GATE=0, DONE=1 for one cycle, PERIOD and STEP_IDX held.
- A step is exactly STEP_CYCLES cycles long, with GATE high for STEP_CYCLES-GAP_CYCLES of them (rest entries: GATE low throughout).
- STOP (any state): next cycle state=IDLE, GATE=0, BUSY=0, STEP_STROBE=0; PERIOD/STEP_IDX held; DONE stays 0.
- STOP and START in the same cycle: STOP wins.
- START while BUSY: immediate restart at step 0 with LEN re-latched; the current step is truncated.
- START in the same cycle as a natural end: the restart wins, and DONE is not pulsed.
- Writes:
  - Accepted in any state; take effect the following cycle.
  - PERIOD is sampled only at step load, so a write never alters the step in progress.
  - Write and load of the same entry in the same cycle: the load takes the OLD value.
- LEN changes while BUSY are ignored until the next START. LOOP is live.
- STEP_IDX wraps 7→0 only via the LOOP path; LEN=7 plays all 8 entries.

Test Plan (STEP_CYCLES=8, GAP_CYCLES=2):
- Reset, write table[0..3]=191116, 340529, 286352, 227272; LEN=3, LOOP=0, START at cycle T:
  - strobes at T+1, T+9, T+17, T+25.
  - PERIOD follows the table.
  - GATE high 6 cycles, low 2 cycles per step.
  - DONE pulse at T+33; BUSY low from T+33.
- Same table, LOOP=1, LEN=1:
  - STEP_IDX sequence 0,1,0,1…
  - no DONE.
  - STOP at step 1 tick 3 → GATE=0 and BUSY=0 next cycle, STEP_IDX stays 1.
- table[1]=0 (rest), LEN=2: GATE stays 0 for all 8 cycles of step 1; steps 0 and 2 gate normally.
- Write table[1]=111111 during step 0 at tick 7 (same cycle as load of step 1): step 1 PERIOD=old value. A later loop pass shows 111111.
- START mid-step 2 with LEN input changed to 0:
  - strobe next cycle with STEP_IDX=0.
  - single step played, then DONE.
  - START+STOP in the same cycle → stays IDLE.
- Assert RST mid-GAP: next cycle all outputs are 0 and the table reads back 0 (START plays a rest).
